// File: rtl/rsa_word_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : rsa_word_sequencer
// Description : Word-level sequencer for the UART RSA datapath. Collects
//               N-bit words into the message, exponent and modulus operands
//               (least-significant word first), pulses start to the
//               exponentiation core, captures the result on core_done and
//               streams it back out as N-bit words with a valid/ready
//               handshake toward the serializer.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               rx_valid, rx_bytes  - incoming words from serial_to_parallel
//               msg, exp, mod       - operand registers to the core
//               start               - one-cycle launch pulse to the core
//               core_done/result    - completion strobe and result from core
//               tx_valid/bytes/ready- outgoing words to parallel_to_serial
//               busy                - low only when idle (LOAD_MSG, count 0)
//               drop_err            - sticky flag: a word arrived unaccepted
// Revision    : 1.0 - initial release
// ============================================================================
module rsa_word_sequencer #(
    parameter int N      = 32,
    parameter int bitLen = 64,
    parameter int WORDS  = bitLen / N,
    parameter int WCNT_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [N-1:0]      rx_bytes,
    output logic [bitLen-1:0] msg,
    output logic [bitLen-1:0] exp,
    output logic [bitLen-1:0] mod,
    output logic              start,
    input  logic              core_done,
    input  logic [bitLen-1:0] core_result,
    output logic              tx_valid,
    output logic [N-1:0]      tx_bytes,
    input  logic              tx_ready,
    output logic              busy,
    output logic              drop_err
);

    localparam logic [WCNT_W-1:0] c_last = WCNT_W'(WORDS - 1);

    typedef enum logic [2:0] {
        ST_LOAD_MSG = 3'd0,
        ST_LOAD_EXP = 3'd1,
        ST_LOAD_MOD = 3'd2,
        ST_FIRE     = 3'd3,
        ST_WAIT     = 3'd4,
        ST_SEND     = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [WCNT_W-1:0]   r_wcnt;
    logic [bitLen-1:0]   r_msg;
    logic [bitLen-1:0]   r_exp;
    logic [bitLen-1:0]   r_mod;
    logic [bitLen-1:0]   r_result;
    logic                r_tx_valid;
    logic [N-1:0]        r_tx_bytes;
    logic                r_drop_err;

    logic [WCNT_W-1:0]   w_cnt_inc;
    logic [WCNT_W-1:0]   w_load_cnt;
    logic                w_cnt_last;
    logic                w_tx_xfer;
    logic [N-1:0]        w_next_word;

    assign w_cnt_inc  = r_wcnt + WCNT_W'(1);
    assign w_cnt_last = (r_wcnt == c_last);
    assign w_load_cnt = w_cnt_last ? '0 : w_cnt_inc;
    assign w_tx_xfer  = r_tx_valid && tx_ready;

    // Result word that follows the one currently presented on tx_bytes.
    always_comb begin
        w_next_word = '0;
        for (int w = 0; w < WORDS; w++) begin
            if (w_cnt_inc == WCNT_W'(w)) begin
                w_next_word = r_result[w*N +: N];
            end
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_LOAD_MSG;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_LOAD_MSG: if (rx_valid && w_cnt_last) w_next_state = ST_LOAD_EXP;
            ST_LOAD_EXP: if (rx_valid && w_cnt_last) w_next_state = ST_LOAD_MOD;
            ST_LOAD_MOD: if (rx_valid && w_cnt_last) w_next_state = ST_FIRE;
            ST_FIRE:     w_next_state = ST_WAIT;
            ST_WAIT:     if (core_done) w_next_state = ST_SEND;
            ST_SEND:     if (w_tx_xfer && w_cnt_last) w_next_state = ST_LOAD_MSG;
            default:     w_next_state = ST_LOAD_MSG;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand capture, result capture and word streaming
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wcnt     <= '0;
            r_msg      <= '0;
            r_exp      <= '0;
            r_mod      <= '0;
            r_result   <= '0;
            r_tx_valid <= 1'b0;
            r_tx_bytes <= '0;
            r_drop_err <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD_MSG: begin
                    if (rx_valid) begin
                        for (int w = 0; w < WORDS; w++) begin
                            if (r_wcnt == WCNT_W'(w)) r_msg[w*N +: N] <= rx_bytes;
                        end
                        r_wcnt <= w_load_cnt;
                    end
                end
                ST_LOAD_EXP: begin
                    if (rx_valid) begin
                        for (int w = 0; w < WORDS; w++) begin
                            if (r_wcnt == WCNT_W'(w)) r_exp[w*N +: N] <= rx_bytes;
                        end
                        r_wcnt <= w_load_cnt;
                    end
                end
                ST_LOAD_MOD: begin
                    if (rx_valid) begin
                        for (int w = 0; w < WORDS; w++) begin
                            if (r_wcnt == WCNT_W'(w)) r_mod[w*N +: N] <= rx_bytes;
                        end
                        r_wcnt <= w_load_cnt;
                    end
                end
                ST_FIRE: begin
                    if (rx_valid) r_drop_err <= 1'b1;
                end
                ST_WAIT: begin
                    if (rx_valid) r_drop_err <= 1'b1;
                    if (core_done) begin
                        r_result   <= core_result;
                        r_tx_valid <= 1'b1;
                        r_tx_bytes <= core_result[N-1:0];
                        r_wcnt     <= '0;
                    end
                end
                ST_SEND: begin
                    if (rx_valid) r_drop_err <= 1'b1;
                    if (w_tx_xfer) begin
                        if (w_cnt_last) begin
                            r_tx_valid <= 1'b0;
                            r_tx_bytes <= '0;
                            r_wcnt     <= '0;
                        end else begin
                            r_tx_bytes <= w_next_word;
                            r_wcnt     <= w_cnt_inc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // FIRE lasts exactly one cycle, so decoding it gives a clean single pulse.
    assign start    = (r_state == ST_FIRE);
    assign busy     = !((r_state == ST_LOAD_MSG) && (r_wcnt == '0));
    assign msg      = r_msg;
    assign exp      = r_exp;
    assign mod      = r_mod;
    assign tx_valid = r_tx_valid;
    assign tx_bytes = r_tx_bytes;
    assign drop_err = r_drop_err;

endmodule
`default_nettype wire

// File: tb/tb_rsa_word_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rsa_word_sequencer
// Description : Directed self-checking bench for rsa_word_sequencer
//               (N=32, bitLen=64). Expected values are hand-computed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rsa_word_sequencer;

    logic        clk;
    logic        rst;
    logic        rx_valid;
    logic [31:0] rx_bytes;
    logic [63:0] dut_msg;
    logic [63:0] dut_exp;
    logic [63:0] dut_mod;
    logic        start;
    logic        core_done;
    logic [63:0] core_result;
    logic        tx_valid;
    logic [31:0] tx_bytes;
    logic        tx_ready;
    logic        busy;
    logic        drop_err;

    int n_checks = 0;
    int n_fail   = 0;

    rsa_word_sequencer #(
        .N      (32),
        .bitLen (64),
        .WORDS  (2),
        .WCNT_W (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_valid    (rx_valid),
        .rx_bytes    (rx_bytes),
        .msg         (dut_msg),
        .exp         (dut_exp),
        .mod         (dut_mod),
        .start       (start),
        .core_done   (core_done),
        .core_result (core_result),
        .tx_valid    (tx_valid),
        .tx_bytes    (tx_bytes),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .drop_err    (drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w);
        rx_valid = 1'b1;
        rx_bytes = w;
        tick();
        rx_valid = 1'b0;
        rx_bytes = '0;
    endtask

    // Sends count consecutive words first, first+1, ...
    task automatic load_seq(input logic [31:0] first, input int count);
        for (int i = 0; i < count; i++) send_word(first + 32'(i));
    endtask

    task automatic pulse_done(input logic [63:0] res);
        core_done   = 1'b1;
        core_result = res;
        tick();
        core_done   = 1'b0;
        core_result = '0;
    endtask

    initial begin
        rst = 1'b1; rx_valid = 1'b0; rx_bytes = '0;
        core_done = 1'b0; core_result = '0; tx_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;

        // ---------------- reset state ----------------
        check("rst_msg",      dut_msg,  64'h0);
        check("rst_exp",      dut_exp,  64'h0);
        check("rst_mod",      dut_mod,  64'h0);
        check("rst_start",    start,    64'h0);
        check("rst_tx_valid", tx_valid, 64'h0);
        check("rst_tx_bytes", tx_bytes, 64'h0);
        check("rst_busy",     busy,     64'h0);
        check("rst_drop_err", drop_err, 64'h0);

        // ---------------- full transaction ----------------
        load_seq(32'd1, 5);
        check("t1_start_early", start, 64'h0);
        send_word(32'd6);
        check("t1_start",  start,   64'h1);
        check("t1_msg",    dut_msg, 64'h00000002_00000001);
        check("t1_exp",    dut_exp, 64'h00000004_00000003);
        check("t1_mod",    dut_mod, 64'h00000006_00000005);
        tick();
        check("t1_start_once", start, 64'h0);
        check("t1_busy_wait",  busy,  64'h1);
        pulse_done(64'hAAAA0000_5555FFFF);
        check("t1_txv0",  tx_valid, 64'h1);
        check("t1_word0", tx_bytes, 64'h5555FFFF);
        tick();
        check("t1_txv1",  tx_valid, 64'h1);
        check("t1_word1", tx_bytes, 64'hAAAA0000);
        tick();
        check("t1_txv_end",  tx_valid, 64'h0);
        check("t1_busy_end", busy,     64'h0);

        // ---------------- back-to-back load, drop, backpressure ----------------
        load_seq(32'd11, 6);
        check("b2b_msg",  dut_msg,  64'h0000000C_0000000B);
        check("b2b_exp",  dut_exp,  64'h0000000E_0000000D);
        check("b2b_mod",  dut_mod,  64'h00000010_0000000F);
        check("b2b_drop", drop_err, 64'h0);
        check("b2b_start", start,   64'h1);
        tick();
        send_word(32'hDEADBEEF);
        check("drop_err", drop_err, 64'h1);
        check("drop_msg", dut_msg,  64'h0000000C_0000000B);
        check("drop_exp", dut_exp,  64'h0000000E_0000000D);
        check("drop_mod", dut_mod,  64'h00000010_0000000F);
        check("drop_txv", tx_valid, 64'h0);
        tx_ready = 1'b0;
        pulse_done(64'hAAAA0000_5555FFFF);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("bp_txv_%0d", i),  tx_valid, 64'h1);
            check($sformatf("bp_word_%0d", i), tx_bytes, 64'h5555FFFF);
            if (i < 9) tick();
        end
        tx_ready = 1'b1;
        tick();
        check("bp_word1", tx_bytes, 64'hAAAA0000);
        check("bp_txv1",  tx_valid, 64'h1);
        tick();
        check("bp_txv_end",  tx_valid, 64'h0);
        check("bp_busy_end", busy,     64'h0);
        check("bp_drop_sticky", drop_err, 64'h1);

        // ---------------- reset mid-load ----------------
        load_seq(32'd21, 3);
        check("ml_busy", busy,    64'h1);
        check("ml_msg",  dut_msg, 64'h00000016_00000015);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_msg",  dut_msg,  64'h0);
        check("mr_exp",  dut_exp,  64'h0);
        check("mr_mod",  dut_mod,  64'h0);
        check("mr_drop", drop_err, 64'h0);
        check("mr_busy", busy,     64'h0);
        check("mr_txv",  tx_valid, 64'h0);

        // ---------------- fresh load with spurious done in LOAD_EXP ----------------
        load_seq(32'd1, 3);
        pulse_done(64'h12345678_9ABCDEF0);
        check("sp_txv",   tx_valid, 64'h0);
        check("sp_start", start,    64'h0);
        check("sp_busy",  busy,     64'h1);
        load_seq(32'd4, 3);
        check("fr_msg",   dut_msg, 64'h00000002_00000001);
        check("fr_exp",   dut_exp, 64'h00000004_00000003);
        check("fr_mod",   dut_mod, 64'h00000006_00000005);
        check("fr_start", start,   64'h1);
        check("fr_txv",   tx_valid, 64'h0);
        tick();
        pulse_done(64'h12345678_9ABCDEF0);
        check("fr_word0", tx_bytes, 64'h9ABCDEF0);
        tick();
        check("fr_word1", tx_bytes, 64'h12345678);
        tick();
        check("fr_txv_end", tx_valid, 64'h0);
        check("fr_drop",    drop_err, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
